pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Consumer end of the PLL lock interface: samples the asynchronous `pll_lock` status from the clock-generation stub, drives the PLL reset, and releases the system reset only after lock has been continuously stable. It re-triggers PLL reset on lock timeout, loss of lock or software request, and keeps saturating event counters for debug. It sits beside the PLL and runs on the free-running reference clock, not on any PLL output.

## Interface
- `SYNC_STAGES`, 2, flops in the `pll_lock` synchronizer (>=2)
- `PLL_RST_CYC`, 8, cycles `pll_rst` is held high per attempt (>=1)
- `LOCK_TIMEOUT`, 65536, cycles to wait for lock before retrying (>=2)
- `STABLE_CYC`, 1024, consecutive locked cycles required before release (>=1)
- `clk`  in  1  free-running reference clock, same source as PLL `clkin1`
- `rstn`  in  1  reset; asynchronous, active-low
- `pll_lock`  in  1  PLL lock status, asynchronous to `clk`
- `relock_req`  in  1  single-cycle request to force a new PLL reset
- `pll_rst`  out  1  active-high reset to the PLL
- `sys_rstn`  out  1  active-low reset for downstream logic
- `locked`  out  1  high while in RUN
- `lost_cnt`  out  8  lock losses seen in RUN, saturating at 255
- `retry_cnt`  out  8  lock timeouts, saturating at 255

## Operation
- `pll_lock` passes through `SYNC_STAGES` flops (async-cleared to 0) giving `lock_s`; the FSM uses only `lock_s`.
- One cycle counter `cnt`, width `$clog2` of the largest parameter; cleared to 0 on every state change, otherwise +1 per cycle.
- States: RESET_PLL, WAIT_LOCK, STABLE, RUN. Reset state RESET_PLL.
- RESET_PLL: `pll_rst`=1. When `cnt==PLL_RST_CYC-1` -> WAIT_LOCK.
- WAIT_LOCK: `lock_s`=1 -> STABLE; else `cnt==LOCK_TIMEOUT-1` -> RESET_PLL, `retry_cnt`+1.
- STABLE: `lock_s`=0 -> WAIT_LOCK (no counter change, full wait restarts); `lock_s`=1 and `cnt==STABLE_CYC-1` -> RUN.
- RUN: `lock_s`=0 -> RESET_PLL, `lost_cnt`+1.
- `relock_req`=1 in WAIT_LOCK/STABLE/RUN -> RESET_PLL; highest priority; no counter increments that cycle (including a simultaneous RUN lock loss). Ignored in RESET_PLL (no restart of the hold).
- Outputs are Moore decodes of the registered state: `pll_rst`=(RESET_PLL), `sys_rstn`=`locked`=(RUN). No combinational path from any input to any output.
- Both counters saturate at 255 and clear only on `rstn`.

## Timing
- Reset (`rstn`=0, immediate, async): state RESET_PLL, `cnt`=0, synchronizer 0; `pll_rst`=1, `sys_rstn`=0, `locked`=0, `lost_cnt`=0, `retry_cnt`=0. Applies mid-operation too.
- Edge 1 = first rising `clk` edge with `rstn`=1. `pll_rst` stays high through edge `PLL_RST_CYC`, low after it.
- `pll_lock` to `lock_s`: `SYNC_STAGES` edges. Lock loss in RUN to `sys_rstn` low: `SYNC_STAGES`+1 edges.
- `relock_req` sampled at edge N: state RESET_PLL and `pll_rst`=1 after edge N.
- Min release after reset with lock already high: edge `PLL_RST_CYC`+1+`STABLE_CYC`.
- Retry period with no lock: `PLL_RST_CYC`+`LOCK_TIMEOUT` cycles.

## Test plan
Parameters for all: `SYNC_STAGES`=2, `PLL_RST_CYC`=8, `LOCK_TIMEOUT`=64, `STABLE_CYC`=16.
- `pll_lock`=1 throughout, release `rstn` -> `pll_rst` high through edge 8, STABLE after edge 9, `sys_rstn`=`locked`=1 after edge 25; counters 0.
- `pll_lock`=0 throughout -> `pll_rst` re-rises after edge 72, `retry_cnt`=1; after edge 144 `retry_cnt`=2; `sys_rstn` never rises; after 300 timeouts `retry_cnt`=255.
- `pll_lock` drops for 1 cycle midway through STABLE -> WAIT_LOCK, `sys_rstn` stays 0, counters unchanged, release exactly 17 edges after `lock_s` returns high.
- In RUN, drop `pll_lock` before edge N -> `sys_rstn`=0 after edge N+2, `lost_cnt`=1, `pll_rst` high 8 cycles, re-release 25 edges later with lock restored.
- In RUN, pulse `relock_req` -> RESET_PLL next edge, `lost_cnt`/`retry_cnt` unchanged; pulse coincident with lock-loss transition -> `lost_cnt` unchanged; pulse during RESET_PLL -> hold still 8 cycles total.
- Assert `rstn`=0 mid-RUN with `lost_cnt`=3 -> all outputs to reset values without a clock edge; counters 0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Supervises a PLL from its free-running reference clock. The asynchronous
// lock status is synchronized, the PLL reset is pulsed and the downstream
// system reset is released only after lock has been continuously stable.
// A PLL reset is retriggered on lock timeout, on loss of lock, or on a
// software relock request. Saturating debug counters record lock losses
// and lock timeouts.
//
// Ports:
//   clk         free-running reference clock (same source as PLL clkin1)
//   rstn        asynchronous active-low reset
//   pll_lock    PLL lock status, asynchronous to clk
//   relock_req  single-cycle request to force a new PLL reset
//   pll_rst     active-high reset to the PLL
//   sys_rstn    active-low reset for downstream logic
//   locked      high while the PLL is locked and released (RUN)
//   lost_cnt    lock losses seen in RUN, saturating at 255
//   retry_cnt   lock timeouts, saturating at 255
module pll_lock_supervisor #(
    parameter int SYNC_STAGES  = 2,
    parameter int PLL_RST_CYC  = 8,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STABLE_CYC   = 1024
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rstn,
    output logic       locked,
    output logic [7:0] lost_cnt,
    output logic [7:0] retry_cnt
);

    localparam int MAX_A = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
    localparam int MAX_B = (MAX_A > STABLE_CYC) ? MAX_A : STABLE_CYC;
    localparam int MAX_P = (MAX_B > SYNC_STAGES) ? MAX_B : SYNC_STAGES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   lock_s;
    logic                   inc_retry;
    logic                   inc_lost;

    // Lock status synchronizer; bit 0 is the metastability-catching flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pll_lock};
        end
    end

    assign lock_s = sync[SYNC_STAGES-1];

    // State register and the single per-state cycle counter, which restarts
    // from zero whenever the state changes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= RESET_PLL;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state decode. A relock request outranks every other event and
    // suppresses the counter increment of a simultaneous timeout or loss;
    // it is ignored while the PLL reset is already being held.
    always_comb begin
        state_nx  = state;
        inc_retry = 1'b0;
        inc_lost  = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == HOLD_LAST) begin
                    state_nx = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (relock_req) begin
                    state_nx = RESET_PLL;
                end else if (lock_s) begin
                    state_nx = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx  = RESET_PLL;
                    inc_retry = 1'b1;
                end
            end
            STABLE: begin
                if (relock_req) begin
                    state_nx = RESET_PLL;
                end else if (!lock_s) begin
                    // Lock glitch: restart the full wait without a PLL reset.
                    state_nx = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (relock_req) begin
                    state_nx = RESET_PLL;
                end else if (!lock_s) begin
                    state_nx = RESET_PLL;
                    inc_lost = 1'b1;
                end
            end
            default: begin
                state_nx = RESET_PLL;
            end
        endcase
    end

    // Saturating debug counters; only rstn clears them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lost_cnt  <= 8'd0;
            retry_cnt <= 8'd0;
        end else begin
            if (inc_lost && (lost_cnt != 8'hFF)) begin
                lost_cnt <= lost_cnt + 8'd1;
            end
            if (inc_retry && (retry_cnt != 8'hFF)) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
        end
    end

    // Moore outputs decoded from the registered state only.
    assign pll_rst  = (state == RESET_PLL);
    assign sys_rstn = (state == RUN);
    assign locked   = (state == RUN);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//
// Bench for pll_lock_supervisor with SYNC_STAGES=2, PLL_RST_CYC=8,
// LOCK_TIMEOUT=64, STABLE_CYC=16. Each cycle the stimulus driver applies
// inputs, advances a behavioural reference model by one clock edge and
// queues the expected outputs; a separate monitor pops one expectation per
// falling edge (or per async-reset event) and compares it with the DUT.
// The reference model describes each phase by how many edges it may still
// last (a countdown), and the synchronizer as a history of sampled lock
// values.
module tb_pll_lock_supervisor;

    localparam int SYNC    = 2;
    localparam int HOLD    = 8;
    localparam int TIMEOUT = 64;
    localparam int STAB    = 16;

    localparam int PH_HOLD = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;

    logic       clk;
    logic       rstn;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rstn;
    logic       locked;
    logic [7:0] lost_cnt;
    logic [7:0] retry_cnt;

    pll_lock_supervisor #(
        .SYNC_STAGES (SYNC),
        .PLL_RST_CYC (HOLD),
        .LOCK_TIMEOUT(TIMEOUT),
        .STABLE_CYC  (STAB)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .pll_lock  (pll_lock),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rstn  (sys_rstn),
        .locked    (locked),
        .lost_cnt  (lost_cnt),
        .retry_cnt (retry_cnt)
    );

    typedef struct {
        bit e_pll_rst;
        bit e_sys_rstn;
        bit e_locked;
        int e_lost;
        int e_retry;
    } exp_t;

    exp_t sb[$];
    event chk_ev;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   run_en      = 0;

    // Reference model state
    int ph;
    int remaining;
    int lost_m;
    int retry_m;
    bit hist[SYNC];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void enter(input int p);
        ph = p;
        case (p)
            PH_HOLD: remaining = HOLD;
            PH_WAIT: remaining = TIMEOUT;
            PH_STAB: remaining = STAB;
            default: remaining = 0;
        endcase
    endfunction

    function automatic void model_reset();
        enter(PH_HOLD);
        lost_m  = 0;
        retry_m = 0;
        for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
    endfunction

    function automatic void model_edge(input bit lk, input bit req);
        bit ls;
        ls = hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = lk;
        remaining = remaining - 1;
        case (ph)
            PH_HOLD: begin
                if (remaining == 0) enter(PH_WAIT);
            end
            PH_WAIT: begin
                if (req) enter(PH_HOLD);
                else if (ls) enter(PH_STAB);
                else if (remaining == 0) begin
                    if (retry_m < 255) retry_m++;
                    enter(PH_HOLD);
                end
            end
            PH_STAB: begin
                if (req) enter(PH_HOLD);
                else if (!ls) enter(PH_WAIT);
                else if (remaining == 0) enter(PH_RUN);
            end
            default: begin
                if (req) enter(PH_HOLD);
                else if (!ls) begin
                    if (lost_m < 255) lost_m++;
                    enter(PH_HOLD);
                end
            end
        endcase
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.e_pll_rst  = (ph == PH_HOLD);
        e.e_sys_rstn = (ph == PH_RUN);
        e.e_locked   = (ph == PH_RUN);
        e.e_lost     = lost_m;
        e.e_retry    = retry_m;
        sb.push_back(e);
    endfunction

    // One clock cycle: drive inputs after the falling edge, predict the
    // state after the next rising edge.
    task automatic step(input bit lk, input bit req);
        @(negedge clk);
        #1;
        rstn       = run_en;
        pll_lock   = lk;
        relock_req = req;
        if (rstn) model_edge(lk, req);
        else model_reset();
        push_exp();
    endtask

    // Assert rstn between edges and check outputs without any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #1;
        run_en = 0;
        rstn   = 1'b0;
        #1;
        model_reset();
        push_exp();
        ->chk_ev;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (pll_rst !== e.e_pll_rst || sys_rstn !== e.e_sys_rstn ||
                    locked !== e.e_locked || lost_cnt !== 8'(e.e_lost) ||
                    retry_cnt !== 8'(e.e_retry)) begin
                    miscompares++;
                    if (miscompares <= 20)
                        $display("FAIL outputs @%0t: got pll_rst=%b sys_rstn=%b locked=%b lost=%0d retry=%0d, expected %b %b %b %0d %0d",
                                 $time, pll_rst, sys_rstn, locked, lost_cnt, retry_cnt,
                                 e.e_pll_rst, e.e_sys_rstn, e.e_locked, e.e_lost, e.e_retry);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int mode;
        int len;
        bit lk;
        bit rq;

        rstn       = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        model_reset();
        #1;
        push_exp();
        ->chk_ev;

        // Lock high throughout: release at edge 25.
        repeat (3) step(1, 0);
        run_en = 1;
        repeat (40) step(1, 0);

        // One-cycle lock loss in RUN.
        step(0, 0);
        repeat (40) step(1, 0);

        // Relock request in RUN.
        step(1, 1);
        repeat (40) step(1, 0);

        // Relock request coincident with the lock-loss transition.
        step(0, 0);
        step(0, 0);
        step(0, 1);
        repeat (40) step(1, 0);

        // Relock requests while the PLL reset is held.
        step(1, 1);
        step(1, 0);
        step(1, 0);
        step(1, 1);
        step(1, 1);
        repeat (40) step(1, 0);

        // Lock glitch midway through STABLE.
        step(1, 1);
        repeat (16) step(1, 0);
        step(0, 0);
        repeat (40) step(1, 0);

        // Two more losses so lost_cnt reaches 3, then async reset in RUN.
        step(0, 0);
        repeat (40) step(1, 0);
        step(0, 0);
        repeat (40) step(1, 0);
        async_reset();
        repeat (3) step(1, 0);
        run_en = 1;

        // No lock at all: retries every 72 cycles until retry_cnt saturates.
        repeat (300 * (HOLD + TIMEOUT) + 50) step(0, 0);

        // Randomized lock behaviour with occasional relock requests.
        for (int seg = 0; seg < 120; seg++) begin
            mode = $urandom_range(0, 2);
            len  = $urandom_range(1, 80);
            for (int i = 0; i < len; i++) begin
                if (mode == 0) lk = 1'b1;
                else if (mode == 1) lk = 1'b0;
                else lk = ($urandom_range(0, 3) != 0);
                rq = ($urandom_range(0, 47) == 0);
                step(lk, rq);
            end
        end

        // Repeated losses until lost_cnt saturates.
        repeat (260) begin
            step(0, 0);
            repeat (30) step(1, 0);
        end

        @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
